// File: rtl/uart_core.sv
// uart_core: 8N1 UART; greets with 0xAA, then answers each received byte B with F(B)[7:0] (Fibonacci).
// Latency: F(B) lands on test B+1 cycles after B is taken; replies queue behind any TX frame in flight.
// Backpressure: none on the line; a one-entry buffer keeps only the newest unconsumed byte. Option macro: UART_CORE_ECHO_EN.
module uart_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] test,
    output logic        uart_out,
    input  logic        uart_in
);
    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {SYNC, WAIT_RX, COMPUTE, SEND} ctl_state_t;

    // ---------------- RX ----------------
    rx_state_t     rx_state, rx_state_nxt;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_baud, rx_baud_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_byte_vld, rx_frame_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_in;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nxt;
            rx_baud  <= rx_baud_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_baud_nxt  = rx_baud + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_byte_vld  = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_baud_nxt = '0;
                if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                // A start bit that is high again by mid-bit was a glitch.
                if (rx_baud == HALF_END) begin
                    rx_baud_nxt  = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_baud == BIT_END) begin
                    rx_baud_nxt  = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_baud == BIT_END) begin
                    rx_baud_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    rx_byte_vld  = rx_sync;
                    rx_frame_err = !rx_sync;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_baud, tx_baud_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_line_nxt;
    logic          tx_rdy, tx_go;
    logic [7:0]    tx_byte;

    assign tx_rdy = (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_out <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_baud  <= tx_baud_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            uart_out <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_baud_nxt  = tx_baud + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_line_nxt  = uart_out;
        case (tx_state)
            TX_IDLE: begin
                tx_baud_nxt = '0;
                tx_line_nxt = 1'b1;
                if (tx_go) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = tx_byte;
                    tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_baud == BIT_END) begin
                    tx_baud_nxt  = '0;
                    tx_state_nxt = TX_DATA;
                    tx_line_nxt  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_baud == BIT_END) begin
                    tx_baud_nxt  = '0;
                    tx_shift_nxt = {1'b1, tx_shift[7:1]};
                    tx_line_nxt  = tx_shift[1];
                    tx_bit_nxt   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                        tx_line_nxt  = 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_baud == BIT_END) begin
                    tx_baud_nxt  = '0;
                    tx_state_nxt = TX_GAP;
                end
            end
            TX_GAP: begin
                // Guaranteed idle bit-time before the next start bit.
                if (tx_baud == BIT_END) begin
                    tx_baud_nxt  = '0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // ---------------- controller ----------------
    ctl_state_t  state, state_nxt;
    logic [7:0]  rx_buf;
    logic        pending, ferr;
    logic [31:0] fib_a, fib_b;
    logic [7:0]  fib_cnt;
    logic        take, fib_done;
`ifdef UART_CORE_ECHO_EN
    logic [7:0]  b_reg;
    logic        echo_done;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= SYNC;
            rx_buf  <= '0;
            pending <= 1'b0;
            ferr    <= 1'b0;
            fib_a   <= '0;
            fib_b   <= '0;
            fib_cnt <= '0;
            test    <= '0;
        end else begin
            state <= state_nxt;
            // A byte landing in the same cycle as a take stays pending.
            if (rx_byte_vld) begin
                rx_buf  <= rx_shift;
                pending <= 1'b1;
                ferr    <= 1'b0;
            end else begin
                if (take)         pending <= 1'b0;
                if (rx_frame_err) ferr    <= 1'b1;
            end
            if (take) begin
                fib_a   <= 32'd0;
                fib_b   <= 32'd1;
                fib_cnt <= rx_buf;
            end else if (state == COMPUTE && !fib_done) begin
                fib_a   <= fib_b;
                fib_b   <= fib_a + fib_b;
                fib_cnt <= fib_cnt - 8'd1;
            end
            if (fib_done) test <= fib_a;
        end
    end

`ifdef UART_CORE_ECHO_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_reg     <= '0;
            echo_done <= 1'b0;
        end else begin
            if (take) b_reg <= rx_buf;
            if (state != SEND)                      echo_done <= 1'b0;
            else if (tx_go && !echo_done)           echo_done <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        tx_go     = 1'b0;
        tx_byte   = 8'hAA;
        take      = 1'b0;
        fib_done  = 1'b0;
        case (state)
            SYNC: begin
                if (tx_rdy) begin
                    tx_go     = 1'b1;
                    state_nxt = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (pending) begin
                    take      = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (fib_cnt == 8'd0) begin
                    fib_done  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_go = 1'b1;
`ifdef UART_CORE_ECHO_EN
                    if (!echo_done) begin
                        tx_byte = b_reg;
                    end else begin
                        tx_byte   = test[7:0];
                        state_nxt = WAIT_RX;
                    end
`else
                    tx_byte   = test[7:0];
                    state_nxt = WAIT_RX;
`endif
                end
            end
            default: state_nxt = SYNC;
        endcase
    end
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected reply frames, a line monitor decodes uart_out and compares.
module tb_uart_core;
    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] test;
    logic        uart_out;
    logic        uart_in;

    uart_core #(.CLKS_PER_BIT(BIT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .test     (test),
        .uart_out (uart_out),
        .uart_in  (uart_in)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] tval;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fib(input int n);
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd1;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic [31:0] tv);
        exp_t e;
        e.data = d;
        e.tval = tv;
        exp_q.push_back(e);
    endtask

    task automatic push_reply(input logic [7:0] b, input logic [31:0] f);
`ifdef UART_CORE_ECHO_EN
        push_exp(b, f);
`endif
        push_exp(f[7:0], f);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        uart_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = d[i];
            repeat (BIT) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (BIT) @(negedge clk);
        uart_in = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2 * BIT) @(negedge clk);
    endtask

    // Line monitor: decode every frame on uart_out at mid-bit; a reset mid-frame abandons it.
    logic [7:0]  mon_byte;
    logic [31:0] mon_test;
    logic        mon_stop;
    logic        mon_abort;
    exp_t        mon_exp;

    task automatic mon_wait(input int n, inout logic abort);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rstn) abort = 1'b1;
        end
    endtask

    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && uart_out === 1'b0) begin
                mon_test  = test;
                mon_abort = 1'b0;
                mon_stop  = 1'b0;
                mon_wait(BIT / 2 - 1, mon_abort);
                for (int i = 0; i < 8 && !mon_abort; i++) begin
                    mon_wait(BIT, mon_abort);
                    mon_byte[i] = uart_out;
                end
                if (!mon_abort) begin
                    mon_wait(BIT, mon_abort);
                    mon_stop = uart_out;
                end
                if (!mon_abort) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got 0x%02h, expected no frame", mon_byte);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("tx_byte", {24'd0, mon_byte}, {24'd0, mon_exp.data});
                        check("tx_stop", {31'd0, mon_stop}, 32'd1);
                        check("test_at_frame", mon_test, mon_exp.tval);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] rb;
        int         n;
        rstn    = 1'b0;
        uart_in = 1'b1;
        #30;
        check("reset_uart_out", {31'd0, uart_out}, 32'd1);
        check("reset_test", test, 32'd0);
        check("reset_pending", {31'd0, dut.pending}, 32'd0);
        push_exp(8'hAA, 32'd0);
        #25;
        rstn = 1'b1;
        wait_drain(4000);

        // Directed values with hand-computed results
        push_reply(8'd9, 32'd34);
        send_frame(8'd9, 1'b1);
        wait_drain(4000);
        push_reply(8'd0, 32'd0);
        send_frame(8'd0, 1'b1);
        wait_drain(4000);
        push_reply(8'd1, 32'd1);
        send_frame(8'd1, 1'b1);
        wait_drain(4000);
        push_reply(8'd47, 32'hB11924E1);
        send_frame(8'd47, 1'b1);
        wait_drain(4000);
        push_reply(8'd255, fib(255));
        send_frame(8'd255, 1'b1);
        wait_drain(4000);

        // Framing error is dropped and flagged; the next good frame clears the flag
        send_frame(8'h33, 1'b0);
        repeat (BIT) @(negedge clk);
        check("ferr_set", {31'd0, dut.ferr}, 32'd1);
        push_reply(8'd5, 32'd5);
        send_frame(8'd5, 1'b1);
        wait_drain(4000);
        check("ferr_clear", {31'd0, dut.ferr}, 32'd0);

        for (int k = 0; k < 20; k++) begin
            rb = 8'($urandom_range(0, 255));
            push_reply(rb, fib(int'(rb)));
            send_frame(rb, 1'b1);
            wait_drain(4000);
        end

        // Back-to-back bytes, then reset during the final reply frame
        push_reply(8'd9, 32'd34);
        send_frame(8'd9, 1'b1);
        push_reply(8'd10, 32'd55);
        send_frame(8'd10, 1'b1);
        n = 0;
        while (!(exp_q.size() == 1 && uart_out === 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("last_frame_started", {31'd0, (exp_q.size() == 1 && uart_out === 1'b0)}, 32'd1);
        repeat (3 * BIT) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midframe_reset_uart_out", {31'd0, uart_out}, 32'd1);
        check("midframe_reset_test", test, 32'd0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("reset_hold_uart_out", {31'd0, uart_out}, 32'd1);
        check("reset_hold_state_pending", {31'd0, dut.pending}, 32'd0);
        push_exp(8'hAA, 32'd0);
        rstn = 1'b1;
        wait_drain(4000);

        repeat (30 * BIT) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL default to 434 (115200 baud at a 50 MHz clk) and SHALL set the clock cycles per UART bit for both RX and TX.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single system clock; all state changes on its rising edge.
REQ-003 Port rstn SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port test SHALL be an output, 32 bits wide: the last computed result, registered.
REQ-005 Port uart_out SHALL be an output, 1 bit wide: the UART TX line, 8N1, idle high.
REQ-006 Port uart_in SHALL be an input, 1 bit wide: the UART RX line, 8N1, idle high.

Function
REQ-007 The TX frame SHALL be: start bit 0, data bits 0-7 LSB first, stop bit 1, each bit CLKS_PER_BIT cycles; uart_out SHALL be driven from a register.
REQ-008 The RX path SHALL pass uart_in through a 2-flop synchronizer before any use.
- A synchronized 1->0 transition while RX is idle SHALL start a frame.
- The start bit SHALL be re-checked at CLKS_PER_BIT/2; if it is high, RX SHALL return to idle with no byte produced.
- Each data bit and the stop bit SHALL be sampled at its mid-bit point.
REQ-009 A received frame with stop bit 0 (framing error) SHALL be discarded and SHALL raise an internal ferr flag; ferr SHALL clear when the next frame is received without error.
REQ-010 A valid received byte SHALL be latched into a one-entry holding buffer with a pending flag; a newer byte SHALL overwrite an unconsumed one.
REQ-011 The controller FSM SHALL have the states SYNC, WAIT_RX, COMPUTE and SEND.
- After reset it SHALL enter SYNC, transmit 0xAA once, then go to WAIT_RX.
REQ-012 In WAIT_RX with pending set, the FSM SHALL clear pending, load B = the buffer byte and go to COMPUTE.
REQ-013 COMPUTE SHALL calculate F(B), the Fibonacci number, iteratively with one step per cycle.
- F(0)=0, F(1)=1, modulo 2^32 (overflow wraps).
- It SHALL finish in at most B+2 cycles.
REQ-014 On COMPUTE completion, test SHALL take F(B) and the FSM SHALL go to SEND.
REQ-015 SEND SHALL transmit F(B)[7:0] as one frame and then return to WAIT_RX.
- 0xAA SHALL NOT be re-sent after the first time.
REQ-016 Bytes arriving during COMPUTE or SEND SHALL be buffered per REQ-010 and processed on the return to WAIT_RX.
REQ-017 TX SHALL never start a new frame while a frame is in progress; back-to-back frames SHALL have at least one idle bit-time between them.

Reset
REQ-018 While rstn=0 the block SHALL hold the following, independent of clk:
- test = 0 and uart_out = 1;
- FSM in SYNC, pending = 0, ferr = 0;
- RX and TX idle with all bit and baud counters at 0.
REQ-019 Deassertion of rstn SHALL restart the sequence from SYNC, including a fresh 0xAA transmission.
REQ-020 Reset asserted mid-frame SHALL abort that frame immediately, with uart_out forced high.

Configuration
REQ-021 With macro UART_CORE_ECHO_EN defined, SEND SHALL first transmit the received byte B and then F(B)[7:0].
REQ-022 Without UART_CORE_ECHO_EN, SEND SHALL transmit only F(B)[7:0].

Verification
REQ-023 Release rstn after 55 ns (clk period 20 ns) -> uart_out decodes to 0xAA exactly once; test = 0.
REQ-024 After the 0xAA, send byte 9 on uart_in -> test = 34 (0x22); uart_out sends 0x22 (ECHO_EN: 0x09 then 0x22).
REQ-025 Send bytes 0, 1 and 47 -> test = 0, 1 and 0xB11924E1 respectively; the low bytes 0x00, 0x01 and 0xE1 are transmitted.
REQ-026 Send 255 -> test = F(255) mod 2^32; the result is checked against a software model.
REQ-027 Send a frame with stop bit 0, then a valid byte 5 -> the bad frame is ignored; test = 5; 0x05 is transmitted.
REQ-028 Send bytes 9 and 10 back-to-back, then assert rstn low mid-transmit -> uart_out goes high immediately and test = 0; after release, 0xAA is sent again.
